// File: rtl/payment_pkg.sv
// Shared types and constants for bill settlement and cash handling.
// Latency: none (declarations only).
// Backpressure: n/a.
package payment_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_REFUND   = 3'd4
  } pay_state_e;

  // Change denominations, largest first
  localparam int DENOM_200 = 200;
  localparam int DENOM_100 = 100;
  localparam int DENOM_50  = 50;
  localparam int DENOM_20  = 20;
  localparam int DENOM_10  = 10;

  // Notes the cash-handling stage will accept
  localparam int NUM_NOTE_TYPES = 6;
  localparam int ACCEPTED_NOTES [NUM_NOTE_TYPES] = '{10, 20, 50, 100, 200, 500};

  function automatic logic is_accepted_note(input int value);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_NOTE_TYPES; i++) begin
      if (value == ACCEPTED_NOTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/change_denom_select.sv
// Greedy picker: largest change denomination not exceeding the remaining amount.
// Latency: combinational.
// Backpressure: none; output is 0 when nothing fits (remaining < 10).
module change_denom_select
  import payment_pkg::*;
#(
  parameter int AMT_W = 10
) (
  input  logic [AMT_W:0]   remaining_i,
  output logic [AMT_W-1:0] denom_o
);

  localparam int RW = AMT_W + 1;

  // Priority compare from the largest denomination down
  always_comb begin
    denom_o = '0;
    if (remaining_i >= RW'(DENOM_200))      denom_o = AMT_W'(DENOM_200);
    else if (remaining_i >= RW'(DENOM_100)) denom_o = AMT_W'(DENOM_100);
    else if (remaining_i >= RW'(DENOM_50))  denom_o = AMT_W'(DENOM_50);
    else if (remaining_i >= RW'(DENOM_20))  denom_o = AMT_W'(DENOM_20);
    else if (remaining_i >= RW'(DENOM_10))  denom_o = AMT_W'(DENOM_10);
  end

endmodule

// File: rtl/bill_payment_settlement.sv
// Settles accepted notes against a loaded bill; pays change or refunds via the dispenser.
// Latency: pay_done the cycle after the covering note; one dispense item per handshake.
// Backpressure: disp_value held stable while disp_valid && !disp_ready; valid/value depend on registers only.
module bill_payment_settlement
  import payment_pkg::*;
#(
  parameter int AMT_W          = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bill_load,
  input  logic [AMT_W-1:0] bill_amount,
  input  logic             note_strobe,
  input  logic [AMT_W-1:0] note_value,
  input  logic             cancel,
  input  logic             disp_ready,
  output logic             disp_valid,
  output logic [AMT_W-1:0] disp_value,
  output logic [AMT_W:0]   paid_total,
  output logic             busy,
  output logic             bill_err,
  output logic             pay_done,
  output logic             refund_done
);

  localparam int RW    = AMT_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  // Counter expires after TIMEOUT_CYCLES note-free cycles in COLLECT
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AMT_W-1:0] TEN       = AMT_W'(DENOM_10);
  localparam logic [RW-1:0]    MIN_DENOM = RW'(DENOM_10);

  pay_state_e       state_q, state_d;
  logic [AMT_W-1:0] bill_q, bill_d;
  logic [RW-1:0]    paid_q, paid_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             bill_err_q, bill_err_d;
  logic             refund_done_q, refund_done_d;

  logic [AMT_W-1:0] denom;
  logic             payout;
  logic [RW-1:0]    paid_sum;
  logic [RW-1:0]    rem_after;
  logic             bill_ok;

  change_denom_select #(.AMT_W(AMT_W)) u_denom (
    .remaining_i (rem_q),
    .denom_o     (denom)
  );

  assign payout      = (state_q == ST_DISPENSE) || (state_q == ST_REFUND);
  assign disp_value  = payout ? denom : '0;
  assign disp_valid  = payout && (denom != '0);
  assign paid_total  = paid_q;
  assign busy        = (state_q != ST_IDLE);
  assign pay_done    = (state_q == ST_SETTLE);
  assign bill_err    = bill_err_q;
  assign refund_done = refund_done_q;

  assign paid_sum  = paid_q + {1'b0, note_value};
  assign rem_after = rem_q - {1'b0, disp_value};
  assign bill_ok   = (bill_amount != '0) && ((bill_amount % TEN) == '0);

  // Next-state and datapath updates for the settlement FSM
  always_comb begin
    state_d       = state_q;
    bill_d        = bill_q;
    paid_d        = paid_q;
    rem_d         = rem_q;
    tmr_d         = tmr_q;
    bill_err_d    = 1'b0;
    refund_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bill_load) begin
          if (bill_ok) begin
            bill_d  = bill_amount;
            paid_d  = '0;
            tmr_d   = TMR_LOAD;
            state_d = ST_COLLECT;
          end else begin
            bill_err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (note_strobe) begin
          // Note is credited before cancel is considered; a covered bill wins
          paid_d = paid_sum;
          tmr_d  = TMR_LOAD;
          if (paid_sum >= {1'b0, bill_q}) begin
            state_d = ST_SETTLE;
          end else if (cancel) begin
            rem_d   = paid_sum;
            state_d = ST_REFUND;
          end
        end else if (cancel || (tmr_q == '0)) begin
          rem_d   = paid_q;
          state_d = ST_REFUND;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        rem_d   = paid_q - {1'b0, bill_q};
        state_d = (paid_q == {1'b0, bill_q}) ? ST_IDLE : ST_DISPENSE;
      end
      ST_DISPENSE, ST_REFUND: begin
        // Anything below the smallest denomination is residue and is dropped
        if (!disp_valid) begin
          rem_d         = '0;
          state_d       = ST_IDLE;
          refund_done_d = (state_q == ST_REFUND);
        end else if (disp_ready) begin
          rem_d = rem_after;
          if (rem_after < MIN_DENOM) begin
            rem_d         = '0;
            state_d       = ST_IDLE;
            refund_done_d = (state_q == ST_REFUND);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset forgets any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bill_q        <= '0;
      paid_q        <= '0;
      rem_q         <= '0;
      tmr_q         <= '0;
      bill_err_q    <= 1'b0;
      refund_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bill_q        <= bill_d;
      paid_q        <= paid_d;
      rem_q         <= rem_d;
      tmr_q         <= tmr_d;
      bill_err_q    <= bill_err_d;
      refund_done_q <= refund_done_d;
    end
  end

endmodule

// File: doc/bill_payment_settlement.md
Name: bill_payment_settlement

Overview:
- Sits directly downstream of the cash-handling stage. Consumes its per-note acceptance events (denomination-validated notes) and settles them against a loaded electricity bill amount.
- When the bill is covered, it pulses payment completion and pays out any overpayment as change, one denomination per handshake, to the change dispenser.
- On customer cancel or inactivity timeout, it refunds everything collected through the same dispense path.

Parameters:
- AMT_W, 10, width of bill/note/change amounts in rupees.
- TIMEOUT_CYCLES, 1000, clock cycles with no accepted note in COLLECT before auto-refund; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- bill_load  input  1  one-cycle strobe: latch bill_amount and start a transaction.
- bill_amount  input  AMT_W  bill in rupees; must be nonzero multiple of 10.
- note_strobe  input  1  one-cycle strobe: a validated note was accepted upstream.
- note_value  input  AMT_W  value of the note; sampled only with note_strobe.
- cancel  input  1  customer abort request (level or pulse).
- disp_ready  input  1  change dispenser can take the current item.
- disp_valid  output  1  dispense item is presented.
- disp_value  output  AMT_W  denomination being dispensed (200/100/50/20/10).
- paid_total  output  AMT_W+1  rupees collected in the current transaction.
- busy  output  1  high in every state except IDLE.
- bill_err  output  1  one-cycle pulse: bill_load rejected.
- pay_done  output  1  one-cycle pulse: bill fully covered.
- refund_done  output  1  one-cycle pulse: cancel/timeout refund finished.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; all outputs 0; internal bill, remaining and timeout counter 0.
- States: IDLE, COLLECT, SETTLE, DISPENSE, REFUND.
- IDLE:
  - On bill_load with bill_amount!=0 and bill_amount%10==0: latch the bill, clear paid_total, load the timeout counter, go to COLLECT next cycle.
  - On an invalid bill_load: bill_err pulse the following cycle, stay in IDLE.
  - note_strobe and cancel are ignored in IDLE.
- COLLECT:
  - note_strobe adds note_value to paid_total (AMT_W+1 bits, no overflow possible) and reloads the timeout counter.
  - If the updated paid_total >= bill, go to SETTLE. Otherwise the counter decrements each cycle; at 0, go to REFUND.
  - Simultaneous note_strobe and cancel: the note is credited first, then:
    - go to REFUND if the updated total is still below the bill;
    - go to SETTLE if the bill is covered (cancel loses).
  - bill_load is ignored while busy.
- SETTLE (1 cycle):
  - pay_done pulses.
  - remaining = paid_total - bill (<= 490, always a multiple of 10 for standard notes).
  - If remaining==0, go to IDLE; else go to DISPENSE.
- REFUND entry: remaining = paid_total. If 0, pulse refund_done and go to IDLE.
- DISPENSE/REFUND payout:
  - disp_value = largest denomination in {200,100,50,20,10} that is <= remaining; disp_valid=1.
  - disp_value must stay stable while disp_valid && !disp_ready.
  - On disp_valid && disp_ready: remaining -= disp_value; the next item appears the following cycle (no combinational path from ready to valid/value).
  - When remaining reaches 0: disp_valid=0, refund_done pulses (REFUND only), go to IDLE.
  - If remaining is nonzero but <10 (non-standard note upstream), drop the residue and finish.
- paid_total holds its value through SETTLE/DISPENSE/REFUND and clears on the next accepted bill_load.
- note_strobe outside COLLECT is ignored; cancel outside COLLECT is ignored.
- Reset mid-transaction: immediate return to IDLE, disp_valid drops asynchronously, collected amount forgotten.

Decomposition:
- Shared package `payment_pkg`:
  - state enum;
  - denomination constants (DENOM_200…DENOM_10);
  - accepted-note list {10,20,50,100,200,500}, shared with cash handling.
- Sub-module `change_denom_select`: combinational greedy picker, remaining -> largest denomination <= remaining, or 0 if none.

Test Plan:
- Bill 350, notes 200,100,50, disp_ready=1 -> paid_total 350, pay_done 1 cycle after last note, no disp_valid, back to IDLE.
- Bill 130, single note 500 -> pay_done, then disp_value sequence 200,100,50,20 (sum 370), disp_valid low afterwards.
- Bill 300, notes 100 then 50, then cancel; disp_ready held 0 for 3 cycles -> disp_value 100 held stable, then 100 then 50 dispensed, refund_done pulse.
- Bill 200, one note 20, then no notes for TIMEOUT_CYCLES -> refund of 20 through REFUND path, refund_done.
- bill_load with 0 and with 125 -> bill_err pulse each time, busy stays 0. bill_load=300 while busy -> ignored, bill unchanged.
- Reset asserted mid-DISPENSE with disp_valid high -> outputs 0 immediately. After release, IDLE accepts a new bill of 100 and paid_total is 0.
